vga_text_term_ctrl: RTL and testbench

//  Terminal-style sequencer for the 64x30 VGA text buffer: turns a byte stream from
//  the CPU IO path into cell writes, cursor moves, clear-screen and one-row scroll.

---
 rtl/vga_text_term_ctrl.sv | 176 +++++++++++++++++
 tb/tb_vga_text_term_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_term_ctrl.sv
// Byte-stream terminal sequencer for the 64x30 text buffer: cell writes, cursor control,
// clear-screen and one-row scroll, all through a single write port and a 1-cycle read port.
module vga_text_term_ctrl #(
  parameter int         COLS       = 64,
  parameter int         ROWS       = 30,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        busy,
  output logic        mem_re,
  output logic [10:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [10:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic [5:0]  cur_col,
  output logic [4:0]  cur_row
);

  localparam logic [10:0] LAST_IDX   = 11'(COLS * ROWS - 1);
  localparam logic [10:0] COPY_FIRST = 11'(COLS);
  localparam logic [10:0] FILL_FIRST = 11'((ROWS - 1) * COLS);
  localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, PUT, CLEAR, SCR_COPY, SCR_DRAIN, SCR_FILL
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] idx_q, idx_d;
  logic        re_q, re_d;
  logic [10:0] raddr_q, raddr_d;
  logic        we_q, we_d;
  logic [10:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        copy_wr_q, copy_wr_d;
  logic        start_scroll;

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      re_q      <= 1'b0;
      raddr_q   <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      copy_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      re_q      <= re_d;
      raddr_q   <= raddr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      copy_wr_q <= copy_wr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    idx_d        = idx_q;
    re_d         = 1'b0;
    raddr_d      = raddr_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    copy_wr_d    = 1'b0;
    start_scroll = 1'b0;

    case (state_q)
      IDLE: begin
        if (ch_valid) begin
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            state_d = PUT;
            we_d    = 1'b1;
            waddr_d = {row_q, col_q};
            wdata_d = ch_data;
          end else begin
            case (ch_data)
              8'h0A: begin
                col_d = '0;
                if (row_q == LAST_ROW) start_scroll = 1'b1;
                else                   row_d = row_q + 5'd1;
              end
              8'h0D: col_d = '0;
              8'h08: if (col_q != 6'd0) col_d = col_q - 6'd1;
              8'h0C: begin
                col_d   = '0;
                row_d   = '0;
                state_d = CLEAR;
                we_d    = 1'b1;
                idx_d   = '0;
                waddr_d = '0;
                wdata_d = BLANK_CHAR;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        state_d = IDLE;
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) start_scroll = 1'b1;
          else                   row_d = row_q + 5'd1;
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      CLEAR, SCR_FILL: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          idx_d   = idx_q + 11'd1;
          waddr_d = idx_q + 11'd1;
        end
      end
      SCR_COPY: begin
        // The write for the cell read this cycle lands next cycle, taking the read data directly.
        we_d      = 1'b1;
        copy_wr_d = 1'b1;
        waddr_d   = idx_q - COPY_FIRST;
        if (idx_q == LAST_IDX) begin
          state_d = SCR_DRAIN;
        end else begin
          re_d    = 1'b1;
          idx_d   = idx_q + 11'd1;
          raddr_d = idx_q + 11'd1;
        end
      end
      SCR_DRAIN: begin
        state_d = SCR_FILL;
        we_d    = 1'b1;
        idx_d   = FILL_FIRST;
        waddr_d = FILL_FIRST;
        wdata_d = BLANK_CHAR;
      end
      default: state_d = IDLE;
    endcase

    if (start_scroll) begin
      state_d = SCR_COPY;
      re_d    = 1'b1;
      idx_d   = COPY_FIRST;
      raddr_d = COPY_FIRST;
    end
  end

  assign ch_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_re    = re_q;
  assign mem_raddr = raddr_q;
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = copy_wr_q ? mem_rdata : wdata_q;
  assign cur_col   = col_q;
  assign cur_row   = row_q;

endmodule

// File: tb/tb_vga_text_term_ctrl.sv
// Bench for vga_text_term_ctrl: behavioural text-buffer model, write scoreboard,
// cursor vector table and hand sequences for clear, scroll and reset corner cases.
module tb_vga_text_term_ctrl;

  logic        VGA_CLK = 1'b0;
  logic        reset = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready, busy, mem_re, mem_we;
  logic [10:0] mem_raddr, mem_waddr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;

  always #5 VGA_CLK = ~VGA_CLK;

  vga_text_term_ctrl dut (
    .VGA_CLK  (VGA_CLK),
    .reset    (reset),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .busy     (busy),
    .mem_re   (mem_re),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .cur_col  (cur_col),
    .cur_row  (cur_row)
  );

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    logic       wr;
    logic [5:0] col;
    logic [4:0] row;
  } vec_t;

  wr_t        sb[$];
  wr_t        mon_e;
  logic [7:0] mem [0:2047];
  logic [7:0] exp_scr [0:2047];
  int         checks = 0;
  int         failures = 0;
  logic [5:0] trk_col = 6'd0;
  logic [4:0] trk_row = 5'd0;
  vec_t       vecs [14];

  // Text buffer with 1-cycle registered read
  always @(posedge VGA_CLK) begin
    if (mem_re) mem_rdata <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always @(negedge VGA_CLK) begin
    if (reset && mem_we) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_waddr, mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (mem_waddr !== mon_e.addr || mem_wdata !== mon_e.data) begin
          failures++;
          $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_waddr, mem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [10:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
    exp_scr[a] = d;
  endtask

  task automatic model_scroll();
    for (int i = 64; i < 1920; i++) push(11'(i - 64), exp_scr[i]);
    for (int i = 1856; i < 1920; i++) push(11'(i), 8'h20);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push({trk_row, trk_col}, b);
      if (trk_col == 6'd63) begin
        trk_col = 6'd0;
        if (trk_row == 5'd29) model_scroll();
        else trk_row = trk_row + 5'd1;
      end else begin
        trk_col = trk_col + 6'd1;
      end
    end else if (b == 8'h0A) begin
      trk_col = 6'd0;
      if (trk_row == 5'd29) model_scroll();
      else trk_row = trk_row + 5'd1;
    end else if (b == 8'h0D) begin
      trk_col = 6'd0;
    end else if (b == 8'h08) begin
      if (trk_col != 6'd0) trk_col = trk_col - 6'd1;
    end else if (b == 8'h0C) begin
      trk_col = 6'd0;
      trk_row = 5'd0;
      for (int i = 0; i < 1920; i++) push(11'(i), 8'h20);
    end
  endtask

  // Returns just after the accepting clock edge
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    model_byte(b);
    @(negedge VGA_CLK);
    ch_valid = 1'b1;
    ch_data  = b;
    while (!ch_ready && n < 5000) begin
      @(negedge VGA_CLK);
      n++;
    end
    if (!ch_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ch_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge VGA_CLK);
    #1 ch_valid = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    @(negedge VGA_CLK);
    while (busy && n < 5000) begin
      n++;
      @(negedge VGA_CLK);
    end
  endtask

  task automatic check_cursor(input string name, input int c, input int r);
    chk({name, "_col"}, cur_col, c);
    chk({name, "_row"}, cur_row, r);
    $display("txn %s: cursor (%0d,%0d)", name, cur_col, cur_row);
  endtask

  task automatic check_row(input int r, input logic [7:0] v);
    int bad;
    bad = 0;
    for (int c = 0; c < 64; c++) if (mem[r*64 + c] !== v) bad++;
    chk($sformatf("row%0d_bad_cells", r), bad, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ch_ready"}, ch_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_raddr"}, mem_raddr, 0);
    chk({tag, "_mem_waddr"}, mem_waddr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cur_col"}, cur_col, 0);
    chk({tag, "_cur_row"}, cur_row, 0);
    $display("txn %s: reset values sampled", tag);
  endtask

  initial begin
    int n;
    vecs[0]  = '{8'h0D, 1'b0, 6'd0, 5'd0};
    vecs[1]  = '{8'h08, 1'b0, 6'd0, 5'd0};
    vecs[2]  = '{8'h0A, 1'b0, 6'd0, 5'd1};
    vecs[3]  = '{8'h78, 1'b1, 6'd1, 5'd1};
    vecs[4]  = '{8'h08, 1'b0, 6'd0, 5'd1};
    vecs[5]  = '{8'h01, 1'b0, 6'd0, 5'd1};
    vecs[6]  = '{8'h7F, 1'b0, 6'd0, 5'd1};
    vecs[7]  = '{8'h7E, 1'b1, 6'd1, 5'd1};
    vecs[8]  = '{8'h20, 1'b1, 6'd2, 5'd1};
    vecs[9]  = '{8'h1B, 1'b0, 6'd2, 5'd1};
    vecs[10] = '{8'h0A, 1'b0, 6'd0, 5'd2};
    vecs[11] = '{8'h0A, 1'b0, 6'd0, 5'd3};
    vecs[12] = '{8'h0A, 1'b0, 6'd0, 5'd4};
    vecs[13] = '{8'h0A, 1'b0, 6'd0, 5'd5};

    for (int i = 0; i < 2048; i++) begin
      mem[i] <= 8'h00;
      exp_scr[i] = 8'h00;
    end

    repeat (3) @(negedge VGA_CLK);
    check_reset_vals("reset");
    reset = 1'b1;

    // 'A','B' with ch_valid held: ready drops exactly one cycle after each accept
    model_byte(8'h41);
    model_byte(8'h42);
    @(negedge VGA_CLK);
    ch_valid = 1'b1;
    ch_data  = 8'h41;
    @(negedge VGA_CLK);
    chk("ready_after_A", ch_ready, 0);
    ch_data = 8'h42;
    @(negedge VGA_CLK);
    chk("ready_before_B", ch_ready, 1);
    @(negedge VGA_CLK);
    chk("ready_after_B", ch_ready, 0);
    ch_valid = 1'b0;
    @(negedge VGA_CLK);
    chk("ready_idle_B", ch_ready, 1);
    check_cursor("ab", 2, 0);

    for (int k = 0; k < 14; k++) begin
      send(vecs[k].b);
      busy_len(n);
      chk($sformatf("vec%0d_busy", k), n, vecs[k].wr ? 1 : 0);
      chk($sformatf("vec%0d_col", k), cur_col, vecs[k].col);
      chk($sformatf("vec%0d_row", k), cur_row, vecs[k].row);
      $display("txn vec%0d: byte=%h busy=%0d cursor (%0d,%0d)", k, vecs[k].b, n, cur_col, cur_row);
    end

    // Full row 5: wraps to row 6 without scrolling
    for (int i = 0; i < 64; i++) send(8'(8'h61 + i % 26));
    busy_len(n);
    chk("row5_last_busy", n, 1);
    check_cursor("row5_full", 0, 6);

    for (int i = 0; i < 17; i++) send(8'h51);
    busy_len(n);
    check_cursor("col17", 17, 6);
    send(8'h0D);
    busy_len(n);
    chk("cr_busy", n, 0);
    check_cursor("cr_col17", 0, 6);

    // Preload buffer with row number, then LF on the last row
    @(negedge VGA_CLK);
    for (int i = 0; i < 2048; i++) begin
      mem[i] <= (i < 1920) ? 8'(i / 64) : 8'h00;
      exp_scr[i] = (i < 1920) ? 8'(i / 64) : 8'h00;
    end
    for (int i = 0; i < 23; i++) send(8'h0A);
    busy_len(n);
    check_cursor("to_row29", 0, 29);
    send(8'h0A);
    busy_len(n);
    chk("lf_scroll_busy", n, 1921);
    check_cursor("lf_scroll", 0, 29);
    for (int r = 0; r < 29; r++) check_row(r, 8'(r + 1));
    check_row(29, 8'h20);

    // Clear from (10,7)
    send(8'h0C);
    busy_len(n);
    chk("ff1_busy", n, 1920);
    for (int i = 0; i < 7; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'(8'h30 + i));
    busy_len(n);
    check_cursor("pre_ff", 10, 7);
    send(8'h0C);
    busy_len(n);
    chk("ff2_busy", n, 1920);
    check_cursor("ff2", 0, 0);
    for (int r = 0; r < 30; r++) check_row(r, 8'h20);

    // Printable at (63,29): write, wrap and scroll
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 63; i++) send(8'h4B);
    busy_len(n);
    check_cursor("pre_wrap", 63, 29);
    send(8'h4C);
    busy_len(n);
    chk("wrap_scroll_busy", n, 1922);
    check_cursor("wrap_scroll", 0, 29);
    chk("wrap_last_cell", mem[28*64 + 63], 8'h4C);
    chk("wrap_first_cell", mem[28*64], 8'h4B);
    check_row(29, 8'h20);
    chk("sb_empty_pre_reset", sb.size(), 0);

    // Reset in the middle of a scroll
    send(8'h0A);
    repeat (500) @(negedge VGA_CLK);
    chk("scroll_busy_at_500", busy, 1);
    @(posedge VGA_CLK);
    #2 reset = 1'b0;
    sb.delete();
    trk_col = 6'd0;
    trk_row = 5'd0;
    @(negedge VGA_CLK);
    check_reset_vals("mid_reset");
    reset = 1'b1;
    @(negedge VGA_CLK);
    chk("post_reset_ready", ch_ready, 1);
    send(8'h5A);
    busy_len(n);
    chk("z_busy", n, 1);
    check_cursor("z", 1, 0);
    chk("z_cell", mem[0], 8'h5A);
    chk("sb_empty_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
